// File: rtl/reg_dst_pkg.sv
// Shared encodings and the per-stage record for the destination-register tracker.
package reg_dst_pkg;

    localparam logic [1:0] DST_RT   = 2'b00;
    localparam logic [1:0] DST_RD   = 2'b01;
    localparam logic [1:0] DST_LINK = 2'b10;
    localparam logic [1:0] DST_NONE = 2'b11;

    localparam logic [2:0] FWD_NONE = 3'd7;

    // MIPS-32 register index width; the stage record is sized from it.
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] dst;
        logic                  we;
    } stage_t;

endpackage

// File: rtl/reg_dst_pipe_if.sv
// Decode-side controls and tracker outputs for reg_dst_pipe; master drives decode, slave is the tracker.
interface reg_dst_pipe_if
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DEPTH  = 3
);
    logic                    in_valid;
    logic [ADDR_W-1:0]       rt_i;
    logic [ADDR_W-1:0]       rd_i;
    logic [1:0]              dst_sel_i;
    logic                    reg_write_i;
    logic                    stall_i;
    logic                    flush_i;
    logic [ADDR_W-1:0]       src_rs_i;
    logic [ADDR_W-1:0]       src_rt_i;
    logic [DEPTH*ADDR_W-1:0] stg_dst_o;
    logic [DEPTH-1:0]        stg_we_o;
    logic [DEPTH-1:0]        hit_rs_o;
    logic [DEPTH-1:0]        hit_rt_o;
    logic [2:0]              fwd_rs_o;
    logic [2:0]              fwd_rt_o;
    logic [ADDR_W-1:0]       wb_dst_o;
    logic                    wb_we_o;

    modport master (
        output in_valid, rt_i, rd_i, dst_sel_i, reg_write_i, stall_i, flush_i,
               src_rs_i, src_rt_i,
        input  stg_dst_o, stg_we_o, hit_rs_o, hit_rt_o, fwd_rs_o, fwd_rt_o,
               wb_dst_o, wb_we_o
    );

    modport slave (
        input  in_valid, rt_i, rd_i, dst_sel_i, reg_write_i, stall_i, flush_i,
               src_rs_i, src_rt_i,
        output stg_dst_o, stg_we_o, hit_rs_o, hit_rt_o, fwd_rs_o, fwd_rt_o,
               wb_dst_o, wb_we_o
    );

endinterface

// File: rtl/reg_dst_sel.sv
// Destination select (rt / rd / link / none) with write-enable qualification.
// Link selection is present only when REG_DST_LINK_EN is defined.
module reg_dst_sel
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int LINK_REG = 31
) (
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_rt,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic [1:0]        i_sel,
    input  logic              i_reg_write,
    output logic [ADDR_W-1:0] o_dst,
    output logic              o_we
);
    logic [ADDR_W-1:0] w_link;
    logic              w_has_dst;

`ifdef REG_DST_LINK_EN
    assign w_link = ADDR_W'(LINK_REG);
`else
    logic [ADDR_W-1:0] w_link_unused;
    assign w_link_unused = ADDR_W'(LINK_REG);
    assign w_link        = '0;
`endif

    always_comb begin
        o_dst     = '0;
        w_has_dst = 1'b0;
        // An invalid slot enters as a bubble, so its destination is zeroed too.
        if (i_valid) begin
            case (i_sel)
                DST_RT:   begin o_dst = i_rt;   w_has_dst = 1'b1; end
                DST_RD:   begin o_dst = i_rd;   w_has_dst = 1'b1; end
`ifdef REG_DST_LINK_EN
                DST_LINK: begin o_dst = w_link; w_has_dst = 1'b1; end
`endif
                default:  begin o_dst = '0;     w_has_dst = 1'b0; end
            endcase
        end
    end

    assign o_we = i_valid & i_reg_write & w_has_dst & (o_dst != '0);

endmodule

// File: rtl/reg_dst_pipe.sv
// Destination tracker: selects the write destination, carries it through DEPTH stages with
// stall/flush, and reports per-stage source hits plus the youngest forwarding stage.
// Optional feature macro: REG_DST_LINK_EN (link register selection for dst_sel 2'b10).
module reg_dst_pipe
    import reg_dst_pkg::*;
#(
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int DEPTH    = 3,
    parameter int LINK_REG = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    reg_dst_pipe_if.slave   bus
);
    logic [ADDR_W-1:0] w_dst;
    logic              w_we;
    stage_t            w_new;
    stage_t            r_stg [DEPTH];
    logic [DEPTH-1:0]  w_hit_rs;
    logic [DEPTH-1:0]  w_hit_rt;
    logic [2:0]        w_fwd_rs;
    logic [2:0]        w_fwd_rt;

    reg_dst_sel #(
        .ADDR_W   (ADDR_W),
        .LINK_REG (LINK_REG)
    ) u_sel (
        .i_valid     (bus.in_valid),
        .i_rt        (bus.rt_i),
        .i_rd        (bus.rd_i),
        .i_sel       (bus.dst_sel_i),
        .i_reg_write (bus.reg_write_i),
        .o_dst       (w_dst),
        .o_we        (w_we)
    );

    assign w_new.dst = w_dst;
    assign w_new.we  = w_we;

    // Flush wins over stall on stage 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg[0] <= '0;
        end else if (bus.flush_i) begin
            r_stg[0] <= '0;
        end else if (!bus.stall_i) begin
            r_stg[0] <= w_new;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_stg[gi] <= '0;
                end else if (!bus.stall_i) begin
                    r_stg[gi] <= r_stg[gi-1];
                end
            end
        end

        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
            assign bus.stg_dst_o[gi*ADDR_W +: ADDR_W] = r_stg[gi].dst;
            assign bus.stg_we_o[gi] = r_stg[gi].we;
            assign w_hit_rs[gi] = r_stg[gi].we & (r_stg[gi].dst == bus.src_rs_i)
                                & (bus.src_rs_i != '0);
            assign w_hit_rt[gi] = r_stg[gi].we & (r_stg[gi].dst == bus.src_rt_i)
                                & (bus.src_rt_i != '0);
        end
    endgenerate

    // Scan oldest to youngest so the lowest hitting stage is the final assignment.
    always_comb begin
        w_fwd_rs = FWD_NONE;
        w_fwd_rt = FWD_NONE;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_hit_rs[k]) w_fwd_rs = 3'(k);
            if (w_hit_rt[k]) w_fwd_rt = 3'(k);
        end
    end

    assign bus.hit_rs_o = w_hit_rs;
    assign bus.hit_rt_o = w_hit_rt;
    assign bus.fwd_rs_o = w_fwd_rs;
    assign bus.fwd_rt_o = w_fwd_rt;
    assign bus.wb_dst_o = r_stg[DEPTH-1].dst;
    assign bus.wb_we_o  = r_stg[DEPTH-1].we;

endmodule

// File: tb/tb_reg_dst_pipe.sv
// Randomised and directed stimulus for reg_dst_pipe checked against a behavioural stage model.
module tb_reg_dst_pipe;
    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LINK  = 31;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    logic [AW-1:0] m_dst [DEPTH];
    bit            m_we  [DEPTH];

    reg_dst_pipe_if #(.ADDR_W(AW), .DEPTH(DEPTH)) bus ();

    reg_dst_pipe #(.ADDR_W(AW), .DEPTH(DEPTH), .LINK_REG(LINK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_dst[k] = '0;
            m_we[k]  = 1'b0;
        end
    endtask

    // Next-state of the tracked pipeline, from the rules for select, r0 suppression, stall and flush.
    task automatic model_step();
        logic [AW-1:0] nd;
        bit            nw;
        case (bus.dst_sel_i)
            2'd0:    nd = bus.rt_i;
            2'd1:    nd = bus.rd_i;
`ifdef REG_DST_LINK_EN
            2'd2:    nd = AW'(LINK);
`else
            2'd2:    nd = '0;
`endif
            default: nd = '0;
        endcase
        if (!bus.in_valid) nd = '0;
        nw = bus.in_valid && bus.reg_write_i && (bus.dst_sel_i != 2'd3) && (nd != 0);
        if (!bus.stall_i) begin
            for (int k = DEPTH - 1; k >= 1; k--) begin
                m_dst[k] = m_dst[k-1];
                m_we[k]  = m_we[k-1];
            end
            m_dst[0] = nd;
            m_we[0]  = nw;
        end
        if (bus.flush_i) begin
            m_dst[0] = '0;
            m_we[0]  = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [DEPTH*AW-1:0] e_dst;
        logic [DEPTH-1:0]    e_we, e_hrs, e_hrt;
        int                  e_frs, e_frt;
        e_frs = 7;
        e_frt = 7;
        for (int k = 0; k < DEPTH; k++) begin
            e_dst[k*AW +: AW] = m_dst[k];
            e_we[k]  = m_we[k];
            e_hrs[k] = m_we[k] && (m_dst[k] == bus.src_rs_i) && (bus.src_rs_i != 0);
            e_hrt[k] = m_we[k] && (m_dst[k] == bus.src_rt_i) && (bus.src_rt_i != 0);
        end
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (e_hrs[k]) e_frs = k;
            if (e_hrt[k]) e_frt = k;
        end
        check_eq("stg_dst", 32'(bus.stg_dst_o), 32'(e_dst));
        check_eq("stg_we",  32'(bus.stg_we_o),  32'(e_we));
        check_eq("hit_rs",  32'(bus.hit_rs_o),  32'(e_hrs));
        check_eq("hit_rt",  32'(bus.hit_rt_o),  32'(e_hrt));
        check_eq("fwd_rs",  32'(bus.fwd_rs_o),  32'(e_frs));
        check_eq("fwd_rt",  32'(bus.fwd_rt_o),  32'(e_frt));
        check_eq("wb_dst",  32'(bus.wb_dst_o),  32'(m_dst[DEPTH-1]));
        check_eq("wb_we",   32'(bus.wb_we_o),   32'(m_we[DEPTH-1]));
    endtask

    // One transaction: drive, check the current state, clock, advance the model.
    task automatic drive(input bit v, input int rt, input int rd, input int sel, input bit rw,
                         input bit st, input bit fl, input int rs, input int srt);
        bus.in_valid    = v;
        bus.rt_i        = AW'(rt);
        bus.rd_i        = AW'(rd);
        bus.dst_sel_i   = 2'(sel);
        bus.reg_write_i = rw;
        bus.stall_i     = st;
        bus.flush_i     = fl;
        bus.src_rs_i    = AW'(rs);
        bus.src_rt_i    = AW'(srt);
        #1;
        check_all();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
    endtask

    initial begin
        model_clear();
        drive(1'b1, 5, 9, 0, 1'b1, 1'b0, 1'b0, 5, 9);
        drive(1'b1, 5, 9, 0, 1'b1, 1'b0, 1'b0, 5, 0);
        drive(1'b1, 5, 9, 0, 1'b1, 1'b0, 1'b0, 0, 5);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b1, 5, 9, 0, 1'b1, 1'b0, 1'b0, 5, 9);

        // Select encodings, then r0 suppression and idle slots.
        drive(1'b1, 5, 9, 0, 1'b1, 1'b0, 1'b0, 5, 9);
        drive(1'b1, 5, 9, 1, 1'b1, 1'b0, 1'b0, 5, 9);
        drive(1'b1, 5, 9, 2, 1'b1, 1'b0, 1'b0, 31, 9);
        drive(1'b1, 5, 9, 3, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 5, 0, 1, 1'b1, 1'b0, 1'b0, 0, 5);
        drive(1'b0, 5, 9, 0, 1'b1, 1'b0, 1'b0, 9, 5);
        drive(1'b1, 6, 9, 0, 1'b0, 1'b0, 1'b0, 6, 9);

        // r7 in stages 0 and 2 with r3 in between; youngest must win.
        drive(1'b1, 0, 7, 1, 1'b1, 1'b0, 1'b0, 0, 0);
        drive(1'b1, 0, 3, 1, 1'b1, 1'b0, 1'b0, 7, 3);
        drive(1'b1, 0, 7, 1, 1'b1, 1'b0, 1'b0, 7, 3);
        drive(1'b1, 0, 7, 1, 1'b1, 1'b1, 1'b0, 7, 3);

        // Two stall cycles, then stall with flush, then resume.
        drive(1'b1, 0, 12, 1, 1'b1, 1'b1, 1'b0, 7, 3);
        drive(1'b1, 0, 12, 1, 1'b1, 1'b1, 1'b1, 7, 3);
        drive(1'b1, 0, 12, 1, 1'b1, 1'b0, 1'b1, 7, 3);
        drive(1'b1, 0, 12, 1, 1'b1, 1'b0, 1'b0, 7, 12);

        // Back-to-back rd=1..4 streaming to writeback.
        for (int i = 1; i <= 4; i++) drive(1'b1, 0, i, 1, 1'b1, 1'b0, 1'b0, i, 1);
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 0, 0, 3, 1'b0, 1'b0, 1'b0, 2, 4);

        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 9) != 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 9) == 0), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)));
            if (i == 200) begin
                rst_n = 1'b0;
                model_clear();
                #1;
                check_all();
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
